// File: rtl/iguana_preload_arb.sv
// Round-robin arbiter sharing the preload/debug memory port between JTAG, serial link and UART,
// with boot-mode gating of requesters and end-of-computation (EOC) scratch-write detection.
module iguana_preload_arb #(
   parameter int unsigned          AddrWidth   = 64,
   parameter int unsigned          DataWidth   = 64,
   parameter logic [AddrWidth-1:0] ScratchAddr = AddrWidth'(64'h0300_0008)
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [1:0]                boot_mode_i,
   input  logic [2:0]                req_valid_i,
   input  logic [2:0]                req_we_i,
   input  logic [2:0][AddrWidth-1:0] req_addr_i,
   input  logic [2:0][DataWidth-1:0] req_wdata_i,
   output logic [2:0]                req_ready_o,
   output logic [2:0]                rsp_valid_o,
   output logic [DataWidth-1:0]      rsp_rdata_o,
   output logic                      mem_req_o,
   input  logic                      mem_gnt_i,
   output logic                      mem_we_o,
   output logic [AddrWidth-1:0]      mem_addr_o,
   output logic [DataWidth-1:0]      mem_wdata_o,
   input  logic                      mem_rvalid_i,
   input  logic [DataWidth-1:0]      mem_rdata_i,
   output logic                      eoc_valid_o,
   output logic [31:0]               exit_code_o,
   output logic                      busy_o
);

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StRsp
   } state_e;

   state_e                 state_q, state_d;
   logic [1:0]             rr_q, rr_d;
   logic [1:0]             owner_q, owner_d;
   logic [AddrWidth-1:0]   addr_q, addr_d;
   logic [DataWidth-1:0]   wdata_q, wdata_d;
   logic                   we_q, we_d;
   logic [DataWidth-1:0]   rdata_q, rdata_d;
   logic [2:0]             rsp_valid_q, rsp_valid_d;
   logic                   eoc_q, eoc_d;
   logic [31:0]            exit_code_q, exit_code_d;
   logic                   latched_q;
   logic [1:0]             boot_mode_q;

   logic [2:0]             mask;
   logic [2:0]             eligible;
   logic                   pick_found;
   logic [1:0]             pick_idx;

   function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] off);
      logic [2:0] s;
      s = {1'b0, base} + {1'b0, off};
      if (s >= 3'd3) s = s - 3'd3;
      return s[1:0];
   endfunction

   // Until the boot mode has been captured the mask stays empty, so the latch cycle never accepts.
   always_comb begin
      mask = '0;
      if (latched_q) begin
         case (boot_mode_q)
            2'd0:    mask = 3'b111;
            2'd1:    mask = 3'b000;
            default: mask = 3'b001;
         endcase
      end
   end

   assign eligible = req_valid_i & mask;

   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int unsigned i = 0; i < 3; i++) begin
         if (!pick_found && eligible[rr_idx(rr_q, 2'(i))]) begin
            pick_found = 1'b1;
            pick_idx   = rr_idx(rr_q, 2'(i));
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      owner_d     = owner_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      we_d        = we_q;
      rdata_d     = rdata_q;
      rsp_valid_d = '0;
      eoc_d       = eoc_q;
      exit_code_d = exit_code_q;
      req_ready_o = '0;
      mem_req_o   = 1'b0;

      case (state_q)
         StIdle: begin
            if (pick_found) begin
               req_ready_o[pick_idx] = 1'b1;
               owner_d               = pick_idx;
               addr_d                = req_addr_i[pick_idx];
               wdata_d               = req_wdata_i[pick_idx];
               we_d                  = req_we_i[pick_idx];
               state_d               = StReq;
            end
         end
         StReq: begin
            mem_req_o = 1'b1;
            if (mem_gnt_i) begin
               state_d = StRsp;
               if (we_q && (addr_q == ScratchAddr) && wdata_q[0]) begin
                  eoc_d       = 1'b1;
                  exit_code_d = {1'b0, wdata_q[31:1]};
               end
            end
         end
         StRsp: begin
            if (mem_rvalid_i) begin
               rdata_d              = mem_rdata_i;
               rsp_valid_d[owner_q] = 1'b1;
               rr_d                 = (owner_q == 2'd2) ? 2'd0 : owner_q + 2'd1;
               state_d              = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         rr_q        <= '0;
         owner_q     <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         rdata_q     <= '0;
         rsp_valid_q <= '0;
         eoc_q       <= 1'b0;
         exit_code_q <= '0;
         latched_q   <= 1'b0;
         boot_mode_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         owner_q     <= owner_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         rdata_q     <= rdata_d;
         rsp_valid_q <= rsp_valid_d;
         eoc_q       <= eoc_d;
         exit_code_q <= exit_code_d;
         latched_q   <= 1'b1;
         if (!latched_q) boot_mode_q <= boot_mode_i;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rdata_q;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign eoc_valid_o = eoc_q;
   assign exit_code_o = exit_code_q;
   assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_iguana_preload_arb.sv
// Directed bench for iguana_preload_arb: boot-mode gating, round-robin order, stalls, EOC and reset.
module tb_iguana_preload_arb;

   localparam logic [63:0] Scr = 64'h0300_0008;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic [1:0]        boot_mode_i;
   logic [2:0]        req_valid_i;
   logic [2:0]        req_we_i;
   logic [2:0][63:0]  req_addr_i;
   logic [2:0][63:0]  req_wdata_i;
   logic [2:0]        req_ready_o;
   logic [2:0]        rsp_valid_o;
   logic [63:0]       rsp_rdata_o;
   logic              mem_req_o;
   logic              mem_gnt_i;
   logic              mem_we_o;
   logic [63:0]       mem_addr_o;
   logic [63:0]       mem_wdata_o;
   logic              mem_rvalid_i;
   logic [63:0]       mem_rdata_i;
   logic              eoc_valid_o;
   logic [31:0]       exit_code_o;
   logic              busy_o;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   iguana_preload_arb #(
      .AddrWidth   (64),
      .DataWidth   (64),
      .ScratchAddr (Scr)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .boot_mode_i  (boot_mode_i),
      .req_valid_i  (req_valid_i),
      .req_we_i     (req_we_i),
      .req_addr_i   (req_addr_i),
      .req_wdata_i  (req_wdata_i),
      .req_ready_o  (req_ready_o),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_rdata_o  (rsp_rdata_o),
      .mem_req_o    (mem_req_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .eoc_valid_o  (eoc_valid_o),
      .exit_code_o  (exit_code_o),
      .busy_o       (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk_i);
      #2;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rdy"},   64'(req_ready_o), 64'd0);
      chk({tag, "_rspv"},  64'(rsp_valid_o), 64'd0);
      chk({tag, "_rdata"}, rsp_rdata_o,      64'd0);
      chk({tag, "_mreq"},  64'(mem_req_o),   64'd0);
      chk({tag, "_mwe"},   64'(mem_we_o),    64'd0);
      chk({tag, "_maddr"}, mem_addr_o,       64'd0);
      chk({tag, "_mwd"},   mem_wdata_o,      64'd0);
      chk({tag, "_eoc"},   64'(eoc_valid_o), 64'd0);
      chk({tag, "_exit"},  64'(exit_code_o), 64'd0);
      chk({tag, "_busy"},  64'(busy_o),      64'd0);
   endtask

   // Called at post-edge+2; reset released on the following negedge, then the latch edge passes.
   task automatic do_reset(input logic [1:0] mode);
      req_valid_i  = '0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      boot_mode_i  = mode;
      rst_ni       = 1'b0;
      #3;
      rst_ni = 1'b1;
      step();
   endtask

   // Minimum round trip: accept now, grant in first REQ cycle, rvalid in the next.
   task automatic run_txn(input string tag, input logic [2:0] rdy, input logic [63:0] addr,
                          input logic we, input logic [63:0] wd, input logic [63:0] rd,
                          input logic drop);
      chk({tag, "_accept"}, 64'(req_ready_o), 64'(rdy));
      step();
      if (drop) req_valid_i = req_valid_i & ~rdy;
      mem_gnt_i = 1'b1;
      #1;
      chk({tag, "_mreq"},   64'(mem_req_o),   64'd1);
      chk({tag, "_maddr"},  mem_addr_o,       addr);
      chk({tag, "_mwe"},    64'(mem_we_o),    64'(we));
      chk({tag, "_mwd"},    mem_wdata_o,      wd);
      chk({tag, "_busy"},   64'(busy_o),      64'd1);
      chk({tag, "_rdy_req"}, 64'(req_ready_o), 64'd0);
      step();
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rd;
      #1;
      chk({tag, "_mreq_rsp"}, 64'(mem_req_o),   64'd0);
      chk({tag, "_rspv_early"}, 64'(rsp_valid_o), 64'd0);
      step();
      mem_rvalid_i = 1'b0;
      #1;
      chk({tag, "_rspv"},  64'(rsp_valid_o), 64'(rdy));
      chk({tag, "_rdata"}, rsp_rdata_o,      rd);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_ni       = 1'b0;
      boot_mode_i  = 2'd0;
      req_valid_i  = '0;
      req_we_i     = '0;
      req_addr_i   = '0;
      req_wdata_i  = '0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      #12;
      chk_all_zero("reset");

      // Single JTAG read in boot mode 0; latch cycle must not accept.
      @(posedge clk_i);
      #2;
      rst_ni        = 1'b1;
      req_valid_i   = 3'b001;
      req_addr_i[0] = 64'h1000_0000;
      req_we_i      = 3'b000;
      #1;
      chk("latch_cycle_rdy", 64'(req_ready_o), 64'd0);
      step();
      run_txn("jtag_rd", 3'b001, 64'h1000_0000, 1'b0, 64'd0, 64'hDEAD_BEEF, 1'b1);
      chk("jtag_rd_idle", 64'(busy_o), 64'd0);
      step();
      chk("rspv_one_cycle", 64'(rsp_valid_o), 64'd0);
      chk("rdata_hold", rsp_rdata_o, 64'hDEAD_BEEF);

      // Three-way contention, valids held continuously: order 0,1,2,0.
      do_reset(2'd0);
      req_addr_i  = {64'h300, 64'h200, 64'h100};
      req_wdata_i = {64'hC3, 64'hB2, 64'hA1};
      req_we_i    = 3'b010;
      req_valid_i = 3'b111;
      #1;
      run_txn("rr0", 3'b001, 64'h100, 1'b0, 64'hA1, 64'h11, 1'b0);
      run_txn("rr1", 3'b010, 64'h200, 1'b1, 64'hB2, 64'h22, 1'b0);
      run_txn("rr2", 3'b100, 64'h300, 1'b0, 64'hC3, 64'h33, 1'b0);
      run_txn("rr3", 3'b001, 64'h100, 1'b0, 64'hA1, 64'h44, 1'b1);
      req_valid_i = '0;

      // Boot mode 2: only JTAG may be served; later pin changes are ignored.
      step();
      do_reset(2'd2);
      boot_mode_i = 2'd0;
      req_we_i    = '0;
      req_valid_i = 3'b110;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("m2_blk_rdy",  64'(req_ready_o), 64'd0);
         chk("m2_blk_mreq", 64'(mem_req_o),   64'd0);
         step();
      end
      req_valid_i = 3'b111;
      #1;
      run_txn("m2_jtag", 3'b001, 64'h100, 1'b0, 64'hA1, 64'h55, 1'b1);
      chk("m2_after_rdy", 64'(req_ready_o), 64'd0);

      // EOC via UART writes to the scratch register.
      step();
      do_reset(2'd0);
      req_addr_i[2]  = Scr;
      req_wdata_i[2] = 64'h5;
      req_we_i       = 3'b100;
      req_valid_i    = 3'b100;
      #1;
      run_txn("eoc5", 3'b100, Scr, 1'b1, 64'h5, 64'h0, 1'b1);
      chk("eoc5_valid", 64'(eoc_valid_o), 64'd1);
      chk("eoc5_code",  64'(exit_code_o), 64'd2);
      req_wdata_i[2] = 64'h4;
      req_valid_i    = 3'b100;
      #1;
      run_txn("eoc4", 3'b100, Scr, 1'b1, 64'h4, 64'h0, 1'b1);
      chk("eoc4_code", 64'(exit_code_o), 64'd2);
      req_addr_i[2]  = Scr + 64'd8;
      req_wdata_i[2] = 64'h7;
      req_valid_i    = 3'b100;
      #1;
      run_txn("eoc_other", 3'b100, Scr + 64'd8, 1'b1, 64'h7, 64'h0, 1'b1);
      chk("eoc_other_code", 64'(exit_code_o), 64'd2);
      req_addr_i[2]  = Scr;
      req_wdata_i[2] = 64'h1;
      req_valid_i    = 3'b100;
      #1;
      run_txn("eoc1", 3'b100, Scr, 1'b1, 64'h1, 64'h0, 1'b1);
      chk("eoc1_valid", 64'(eoc_valid_o), 64'd1);
      chk("eoc1_code",  64'(exit_code_o), 64'd0);

      // Grant stall with stray rvalid, then reset during RSP.
      step();
      do_reset(2'd0);
      req_addr_i[0]  = 64'hABC0;
      req_wdata_i[0] = 64'h1234;
      req_we_i       = 3'b001;
      req_valid_i    = 3'b001;
      #1;
      chk("stall_accept", 64'(req_ready_o), 64'd1);
      step();
      req_valid_i    = 3'b111;
      req_addr_i[0]  = 64'hFFFF;
      req_wdata_i[0] = 64'hEEEE;
      mem_rvalid_i   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall_mreq",  64'(mem_req_o),   64'd1);
         chk("stall_addr",  mem_addr_o,       64'hABC0);
         chk("stall_wdata", mem_wdata_o,      64'h1234);
         chk("stall_rdy",   64'(req_ready_o), 64'd0);
         chk("stall_rspv",  64'(rsp_valid_o), 64'd0);
         step();
      end
      mem_rvalid_i = 1'b0;
      mem_gnt_i    = 1'b1;
      step();
      mem_gnt_i = 1'b0;
      #1;
      chk("rsp_busy", 64'(busy_o), 64'd1);
      rst_ni      = 1'b0;
      boot_mode_i = 2'd1;
      #1;
      chk_all_zero("midrst");
      #1;
      rst_ni = 1'b1;
      step();
      boot_mode_i = 2'd0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("m1_blk_rdy",  64'(req_ready_o), 64'd0);
         chk("m1_blk_mreq", 64'(mem_req_o),   64'd0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/iguana_preload_arb.md
# iguana_preload_arb

Arbiter and sequencer for the single preload/debug memory port of the Iguana SoC. It shares the port between three preload masters (JTAG debug module, serial link, UART debug), in round-robin order with one outstanding transaction. It gates those masters according to the boot mode latched after reset. It watches writes to the end-of-computation (EOC) scratch register and reports the exit code to the chip-level monitor.

## Interface
- `AddrWidth`, 64, address width of requesters and memory port
- `DataWidth`, 64, data width
- `ScratchAddr`, 64'h0300_0008, EOC scratch register address (exact match, full width)

- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `boot_mode_i`  in  2  boot mode pins; 0 = idle/preload, 1 = SD card, 2/3 = autonomous
- `req_valid_i`  in  3  per-requester request; index 0 JTAG, 1 serial link, 2 UART
- `req_we_i`  in  3  per-requester write enable
- `req_addr_i`  in  3×AddrWidth  per-requester address
- `req_wdata_i`  in  3×DataWidth  per-requester write data
- `req_ready_o`  out  3  one-hot accept pulse
- `rsp_valid_o`  out  3  one-hot response pulse
- `rsp_rdata_o`  out  DataWidth  response data, shared
- `mem_req_o`  out  1  memory request
- `mem_gnt_i`  in  1  memory grant
- `mem_we_o`  out  1  memory write enable
- `mem_addr_o`  out  AddrWidth  memory address
- `mem_wdata_o`  out  DataWidth  memory write data
- `mem_rvalid_i`  in  1  memory response valid; earliest one cycle after grant
- `mem_rdata_i`  in  DataWidth  memory read data
- `eoc_valid_o`  out  1  sticky end-of-computation flag
- `exit_code_o`  out  32  exit code, valid while `eoc_valid_o`
- `busy_o`  out  1  FSM not in IDLE

## Operation
- **Boot-mode latch:** `boot_mode_q` captures `boot_mode_i` on the first rising edge after reset release. It is then frozen until the next reset.
- **Requester enable mask:**
  - mode 0: 3'b111
  - mode 1: 3'b000
  - modes 2/3: 3'b001 (JTAG only, for EOC polling)
  - Masked requesters never see `req_ready_o`.
- **FSM states IDLE, REQ, RSP:**
  - IDLE: eligible = `req_valid_i & mask`. If any requester is eligible, the round-robin pick starts at pointer `rr_q`. For that winner: pulse `req_ready_o`, register its address, data and `we` plus the owner index, then go to REQ. The boot-mode latch cycle counts as IDLE with an empty mask, so no accept happens in it.
  - REQ: drive `mem_req_o=1` with the registered fields. Hold until `mem_gnt_i`, then go to RSP.
  - RSP: wait for `mem_rvalid_i`. Register `mem_rdata_i` into `rsp_rdata_o` and set `rsp_valid_o[owner]` for the next cycle. Then `rr_q` = owner+1 mod 3, and go to IDLE.
- **Response data:** `rsp_rdata_o` holds its value until the next response. For writes it carries whatever the memory returns.
- **EOC detection:** on a grant of a write with `addr==ScratchAddr` and `wdata[0]==1`:
  - set `eoc_valid_o`;
  - `exit_code_o` = zero-extended `wdata[31:1]`.
  - Later EOC writes overwrite `exit_code_o`.
  - Writes with `wdata[0]==0` do not affect EOC.
- **Ignored inputs:** `mem_rvalid_i` outside RSP is ignored. `mem_gnt_i` outside REQ is ignored.

## Timing
- **Reset values:**
  - all outputs 0
  - `rr_q`=0, FSM=IDLE, `boot_mode_q`=0
  - latch pending (not yet captured)
- **Accept latency:** `req_ready_o` is combinational in IDLE, in the same cycle as `req_valid_i`.
- **Memory request:** `mem_req_o` rises the cycle after the accept.
- **Minimum round trip:** gnt in the first REQ cycle and rvalid one cycle later gives 3 cycles from accept to the `rsp_valid_o` pulse. The next accept is possible in that same response cycle.
- **Response pulse:** `rsp_valid_o` lasts exactly one cycle. Requesters must hold valid/fields stable until ready.
- **Fairness:** simultaneous requests are served in round-robin order from `rr_q`. No requester waits more than 2 transactions.
- **EOC latency:** `eoc_valid_o` and `exit_code_o` update one cycle after the granting edge.
- **Reset mid-transaction:** everything clears asynchronously and `mem_req_o` drops immediately. The outstanding response is discarded; the memory side must be reset too.
- **Boot pins:** changes on `boot_mode_i` after the latch have no effect.

## Test plan
- **Boot mode 0, single JTAG read:** JTAG read of 0x1000_0000, gnt immediate, rvalid next cycle with 0xDEAD_BEEF → `rsp_valid_o`=3'b001 three cycles after accept, `rsp_rdata_o`=0xDEAD_BEEF, `busy_o` back to 0.
- **Boot mode 0, all three contend:** all three requesters valid continuously → accept order 0,1,2,0; each `rsp_valid_o` one-hot to the matching index.
- **Boot mode 2:** serial link and UART valid, JTAG idle → no `req_ready_o` for 1/2 and `mem_req_o` stays 0. JTAG then requests → served.
- **EOC:** UART writes 0x0000_0005 to ScratchAddr → `eoc_valid_o`=1, `exit_code_o`=2. A subsequent write of 0x4 → no change. A write of 0x1 → `exit_code_o`=0.
- **Grant stall:** `mem_gnt_i` held low for 5 cycles → `mem_req_o` and address/data stable all 5 cycles, no second accept.
- **Mid-transaction reset:** `rst_ni` pulsed low during RSP → all outputs 0 at once. After release, `boot_mode_i`=1 is latched and all requests are blocked.
